// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants, count-width helper and output FSM encoding for the deserializer
package sipo_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: serial bit assembly with counter, bit-order selection and completion pulse
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data,
  input  logic             data_en,
  input  logic             clear,
  output logic [WIDTH-1:0] next_word,
  output logic             done,
  output logic [CW-1:0]    bit_count
);
  logic [WIDTH-1:0] sr;
  assign next_word = MSB_FIRST ? {sr[WIDTH-2:0], data} : {data, sr[WIDTH-1:1]};
  assign done = data_en && !clear && bit_count == CW'(WIDTH - 1);
  // shift in qualified bits; clear discards the partial word and wins over data_en
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= '0;
      bit_count <= '0;
    end else if (clear) begin
      sr <= '0;
      bit_count <= '0;
    end else if (data_en) begin
      sr <= next_word;
      bit_count <= done ? '0 : bit_count + CW'(1);
    end
  end
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: packs a qualified serial stream into words behind a one-word valid/ready holding stage
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data,
  input  logic             data_en,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);
  state_t state, state_n;
  logic [WIDTH-1:0] next_word;
  logic done, load, drop;
  sipo_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) core (
    .clock(clock), .reset(reset), .data(data), .data_en(data_en), .clear(clear),
    .next_word(next_word), .done(done), .bit_count(bit_count)
  );
  assign word_valid = (state == ST_FULL);
  // a completed word is loaded when the holding register is free or being drained, otherwise it is lost
  always_comb begin
    load = done && (state == ST_EMPTY || word_ready);
    drop = done && state == ST_FULL && !word_ready;
    state_n = done ? ST_FULL : (state == ST_FULL && word_ready) ? ST_EMPTY : state;
  end
  // holding register, output state and sticky overrun
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      word <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      word <= load ? next_word : word;
      overrun <= clear ? 1'b0 : (drop ? 1'b1 : overrun);
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench for both bit orders of the deserializer
module tb_sipo_deserializer;
  logic clock = 1'b0, reset = 1'b1, data = 1'b0, data_en = 1'b0, clear = 1'b0, word_ready = 1'b0;
  logic [7:0] word_m, word_l;
  logic valid_m, valid_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  int mcnt = 0;
  bit mvalid = 0, movr = 0;
  logic [7:0] exp_m = 8'h00, exp_l = 8'h00;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .data(data), .data_en(data_en), .clear(clear),
    .word(word_m), .word_valid(valid_m), .word_ready(word_ready), .overrun(ovr_m), .bit_count(cnt_m)
  );
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .data(data), .data_en(data_en), .clear(clear),
    .word(word_l), .word_valid(valid_l), .word_ready(word_ready), .overrun(ovr_l), .bit_count(cnt_l)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".cnt_m"}, 32'(cnt_m), 32'(mcnt));
    check({tag, ".cnt_l"}, 32'(cnt_l), 32'(mcnt));
    check({tag, ".valid_m"}, 32'(valid_m), 32'(mvalid));
    check({tag, ".valid_l"}, 32'(valid_l), 32'(mvalid));
    check({tag, ".ovr_m"}, 32'(ovr_m), 32'(movr));
    check({tag, ".ovr_l"}, 32'(ovr_l), 32'(movr));
    check({tag, ".word_m"}, 32'(word_m), 32'(exp_m));
    check({tag, ".word_l"}, 32'(word_l), 32'(exp_l));
  endtask

  task automatic step(input string tag, input logic d, input logic en, input logic clr);
    bit comp;
    logic [7:0] w;
    data = d;
    data_en = en;
    clear = clr;
    comp = en && !clr && mcnt == 7;
    if (clr) begin
      mcnt = 0;
      movr = 0;
    end else if (en) mcnt = comp ? 0 : mcnt + 1;
    if (comp) begin
      if (q.size() == 0) check({tag, ".queue_underflow"}, 32'd1, 32'd0);
      else begin
        w = q.pop_front();
        if (!mvalid || word_ready) begin
          exp_m = w;
          exp_l = rev8(w);
          mvalid = 1;
        end else movr = 1;
      end
    end else if (mvalid && word_ready) mvalid = 0;
    @(posedge clock);
    #1;
    check_all(tag);
    data_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send_seq(input string tag, input logic [7:0] s, input int gap, input logic rdy_last);
    logic keep;
    keep = word_ready;
    q.push_back(s);
    for (int i = 7; i >= 0; i--) begin
      if (i < 7) for (int g = 0; g < gap; g++) step({tag, "_gap"}, 1'b0, 1'b0, 1'b0);
      if (i == 0) word_ready = rdy_last;
      step(tag, s[i], 1'b1, 1'b0);
    end
    word_ready = keep;
  endtask

  task automatic model_reset();
    mcnt = 0;
    mvalid = 0;
    movr = 0;
    exp_m = 8'h00;
    exp_l = 8'h00;
    q.delete();
  endtask

  initial begin
    #1;
    check_all("reset");
    #7 reset = 1'b0;
    word_ready = 1'b1;
    send_seq("t1_a5", 8'hA5, 0, 1'b1);
    step("t1_drain", 1'b0, 1'b0, 1'b0);
    word_ready = 1'b0;
    send_seq("t2_a5", 8'hA5, 0, 1'b0);
    send_seq("t2_3c_drop", 8'h3C, 0, 1'b0);
    word_ready = 1'b1;
    step("t2_accept", 1'b0, 1'b0, 1'b0);
    word_ready = 1'b0;
    step("t3_clear", 1'b0, 1'b0, 1'b1);
    send_seq("t3_a5", 8'hA5, 0, 1'b0);
    send_seq("t3_3c_nobubble", 8'h3C, 0, 1'b1);
    word_ready = 1'b1;
    step("t3_drain", 1'b0, 1'b0, 1'b0);
    send_seq("t4_gapped", 8'hA5, 3, 1'b1);
    step("t4_drain", 1'b0, 1'b0, 1'b0);
    step("t5_p0", 1'b1, 1'b1, 1'b0);
    step("t5_p1", 1'b1, 1'b1, 1'b0);
    step("t5_p2", 1'b0, 1'b1, 1'b0);
    step("t5_clear", 1'b0, 1'b0, 1'b1);
    send_seq("t5_ff", 8'hFF, 0, 1'b1);
    step("t5_drain", 1'b0, 1'b0, 1'b0);
    word_ready = 1'b0;
    send_seq("t5_a5", 8'hA5, 0, 1'b0);
    send_seq("t5_3c_drop", 8'h3C, 0, 1'b0);
    step("t5_clear_ovr", 1'b0, 1'b0, 1'b1);
    word_ready = 1'b1;
    step("t6_drain", 1'b0, 1'b0, 1'b0);
    send_seq("t6_a5", 8'hA5, 0, 1'b1);
    send_seq("t6_first_one", 8'h80, 0, 1'b1);
    for (int i = 0; i < 4; i++) step("t6_partial", 1'(i & 1), 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async_reset");
    #3 reset = 1'b0;
    send_seq("t6_clean", 8'hC3, 0, 1'b1);
    step("t6_drain", 1'b0, 1'b0, 1'b0);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out deserializer that consumes the registered 1-bit stream produced by the d_ff stage, one qualified bit per clock. It packs WIDTH bits into a word and presents it on a valid/ready interface, backed by a one-word holding register. A sticky overrun flag records words lost to back-pressure. It is the first word-oriented stage downstream of the bit-level flip-flop path.

Parameters:
WIDTH, 8, bits per output word (2..32)
MSB_FIRST, 1, 1 = first received bit lands in word[WIDTH-1]; 0 = first bit lands in word[0]

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-high reset
data  input  1  serial bit, driven by the d_ff out
data_en  input  1  qualifies data; a bit is sampled only on edges where data_en=1
clear  input  1  synchronous restart of word assembly; also clears overrun
word  output  WIDTH  assembled word; stable while word_valid=1
word_valid  output  1  word holds an unconsumed value
word_ready  input  1  consumer accepts word on an edge where word_valid=1
overrun  output  1  sticky; a completed word was dropped
bit_count  output  CW  bits collected in the current word (0..WIDTH-1), CW = clog2(WIDTH)

Behaviour:
- Reset (asynchronous, takes effect immediately): shift register=0, bit_count=0, word=0, word_valid=0, overrun=0, output FSM=EMPTY.
- Assembly on an edge with data_en=1 and clear=0:
  - MSB_FIRST=1: shift left and insert data at bit 0.
  - MSB_FIRST=0: shift right and insert data at bit WIDTH-1.
  - bit_count increments.
- Completion: the edge that samples bit WIDTH (bit_count==WIDTH-1 with data_en=1).
  - bit_count wraps to 0.
  - The completed word, including the bit sampled on this edge, is offered to the output stage on the same edge.
  - Latency: word_valid is visible immediately after the completing edge, with no extra cycle.
- data_en=0: the shift register and bit_count hold. Gaps of any length are legal.
- clear=1: bit_count=0, shift register=0, overrun=0. The partial word is discarded.
  - clear has priority over data_en.
  - clear does not touch word or word_valid; a pending word stays pending.
- Output FSM, two states:
  - EMPTY (word_valid=0):
    - completion: load word, go FULL.
    - otherwise: hold.
  - FULL (word_valid=1):
    - word_ready=1, no completion: go EMPTY. word keeps its last value.
    - word_ready=1 and completion on the same edge: load the new word, stay FULL. word_valid stays 1 with no bubble; overrun unchanged.
    - word_ready=0 and completion: the new word is dropped, word keeps the old value, overrun is set to 1, stay FULL.
    - word_ready=0, no completion: hold.
- word_ready while EMPTY is ignored.
- overrun clears only on reset or clear. If clear and a drop happen on the same edge, clear wins and no drop occurs, because clear suppresses completion.
- Reset asserted mid-word or while FULL: all state returns to reset values. No partial word survives.
- Arithmetic: bit_count is unsigned and compares against WIDTH-1 only. Unqualified cycles never increment it.

Decomposition:
- Shared package sipo_pkg holds:
  - DEFAULT_WIDTH=8
  - the clog2-based count-width function
  - the output FSM state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1)
- One sub-module: sipo_shift_core (shift register, bit counter, MSB_FIRST handling, completion pulse, clear).
- The top level instantiates sipo_shift_core and implements the output FSM and overrun.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, word_ready=1; data 1,0,1,0,0,1,0,1 on 8 consecutive data_en edges -> after the 8th edge word=8'hA5 and word_valid=1 for exactly one cycle; bit_count back to 0; overrun=0.
2. word_ready=0; send 0xA5 then 0x3C (16 bits) -> word stays 0xA5 with word_valid=1; overrun=1 after the 16th edge. Then raise word_ready for one edge -> word_valid=0, overrun stays 1.
3. Hold 0xA5 pending; assert word_ready exactly on the edge that completes 0x3C -> word=0x3C, word_valid stays 1 with no gap, overrun=0.
4. Send 0xA5 with data_en deasserted 3 cycles between every bit -> same result as test 1; bit_count holds its value during each gap.
5. Send 3 bits (1,1,0), assert clear for 1 cycle, then send 8 ones -> word=8'hFF with no stale bits. Assert clear while overrun=1 -> overrun=0 and the pending word is unchanged.
6. MSB_FIRST=0; send 1,0,1,0,0,1,0,1 -> word=8'hA5 bit-reversed=8'hA5 (palindrome), then send 1,0,0,0,0,0,0,0 -> word=8'h01. Assert reset after bit 4 of a further word -> all outputs 0 immediately, and the next 8 bits form a clean word.
